// File: rtl/irq_encoder_8x3_if.sv
// Request/grant bundle between the 8-to-3 request encoder and its consumer.
// The encoder is the master: it drives valid/code/pend and samples req/ready.
interface irq_encoder_8x3_if;
  logic [0:7] req;
  logic       ready;
  logic       valid;
  logic [0:2] code;
  logic [0:7] pend;

  modport master (
    input  req,
    input  ready,
    output valid,
    output code,
    output pend
  );

  modport slave (
    output req,
    output ready,
    input  valid,
    input  code,
    input  pend
  );
endinterface

// File: rtl/irq_encoder_8x3.sv
// Registered 8-to-3 request encoder: sticky pending bits, one grant per handshake,
// fixed (RR=0) or round-robin (RR=1) priority.
module irq_encoder_8x3 #(
  parameter int unsigned RR = 0
) (
  input logic               clk,
  input logic               rst_n,
  irq_encoder_8x3_if.master bus
);

  logic [7:0] req_vec;
  logic [7:0] pend_q, pend_d;
  logic [7:0] acc_mask;
  logic [7:0] cand;
  logic       valid_q, valid_d;
  logic [2:0] code_q, code_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] start;
  logic [2:0] sel;
  logic       found;
  logic       hs;
  logic       load;

  // Ports use ascending ranges; internally bit i is request index i.
  for (genvar g = 0; g < 8; g++) begin : g_map
    assign req_vec[g] = bus.req[g];
    assign bus.pend[g] = pend_q[g];
  end

  assign bus.valid = valid_q;
  assign bus.code  = {code_q[0], code_q[1], code_q[2]};

  always_comb begin
    hs       = valid_q & bus.ready;
    load     = ~valid_q | hs;
    acc_mask = '0;
    if (hs) begin
      acc_mask[code_q] = 1'b1;
    end
    // Set wins over clear: a fresh request re-arms the bit just accepted.
    cand   = (pend_q & ~acc_mask) | req_vec;
    pend_d = cand;

    ptr_d = ptr_q;
    if (RR != 0 && hs) begin
      ptr_d = code_q + 3'd1;
    end
    start = (RR != 0) ? ptr_d : 3'd0;
  end

  // Circular search from start; the first set candidate wins.
  always_comb begin
    logic [2:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < 8; off++) begin
      idx = start + 3'(off);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        code_d = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ptr_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_irq_encoder_8x3.sv
// Bench for irq_encoder_8x3: fixed and round-robin instances share stimulus and are
// compared against an index-level reference model of pending requests and grants.
module tb_irq_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:7] tb_req;
  logic       tb_ready;

  always #5 clk = ~clk;

  irq_encoder_8x3_if fx_if ();
  irq_encoder_8x3_if rr_if ();

  assign fx_if.req   = tb_req;
  assign fx_if.ready = tb_ready;
  assign rr_if.req   = tb_req;
  assign rr_if.ready = tb_ready;

  irq_encoder_8x3 #(.RR(0)) u_dut_fx (.clk(clk), .rst_n(rst_n), .bus(fx_if.master));
  irq_encoder_8x3 #(.RR(1)) u_dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if.master));

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model, [0] = fixed priority, [1] = round-robin.
  bit m_pend[2][8];
  bit m_valid[2];
  int m_code[2];
  int m_ptr[2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_valid(input int m);
    return (m != 0) ? int'(rr_if.valid) : int'(fx_if.valid);
  endfunction

  function automatic int dut_code(input int m);
    logic [0:2] c;
    c = (m != 0) ? rr_if.code : fx_if.code;
    return int'(c[0]) + 2 * int'(c[1]) + 4 * int'(c[2]);
  endfunction

  function automatic int dut_pend(input int m);
    logic [0:7] p;
    int r;
    p = (m != 0) ? rr_if.pend : fx_if.pend;
    r = 0;
    for (int i = 0; i < 8; i++) if (p[i] === 1'b1) r += (1 << i);
    return r;
  endfunction

  function automatic int model_pend(input int m);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (m_pend[m][i]) r += (1 << i);
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) m_pend[m][i] = 1'b0;
      m_valid[m] = 1'b0;
      m_code[m]  = 0;
      m_ptr[m]   = 0;
    end
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_step(input int m);
    bit hs;
    int first;
    hs = m_valid[m] && tb_ready;
    if (hs) begin
      m_pend[m][m_code[m]] = 1'b0;
      if (m == 1) m_ptr[m] = (m_code[m] + 1) % 8;
    end
    for (int i = 0; i < 8; i++) if (tb_req[i]) m_pend[m][i] = 1'b1;
    if (!m_valid[m] || hs) begin
      first = -1;
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = (((m == 1) ? m_ptr[m] : 0) + j) % 8;
        if (first < 0 && m_pend[m][idx]) first = idx;
      end
      m_valid[m] = (first >= 0);
      if (first >= 0) m_code[m] = first;
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      string pfx;
      pfx = (m != 0) ? "rr" : "fx";
      check({pfx, "_valid"}, dut_valid(m), int'(m_valid[m]));
      check({pfx, "_code"}, dut_code(m), m_code[m]);
      check({pfx, "_pend"}, dut_pend(m), model_pend(m));
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Called 1 time unit after a rising edge; reset lands mid-cycle.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    tb_req   = '0;
    tb_ready = 1'b0;
    model_reset();
    #1;
    compare_all();
    #12 rst_n = 1'b1;
    tick();

    // Reset with requests pending and a grant on display.
    tb_req[3] = 1'b1;
    tb_req[6] = 1'b1;
    tick();
    tb_req = '0;
    tick();
    check("pre_reset_pend", dut_pend(0), 8'h48);
    async_reset();
    check("reset_valid", dut_valid(0), 0);
    check("reset_pend", dut_pend(1), 0);
    tick();
    check("post_reset_idle", dut_valid(0), 0);

    // Single request on index 5.
    tb_ready  = 1'b1;
    tb_req[5] = 1'b1;
    tick();
    tb_req = '0;
    check("single_valid", dut_valid(0), 1);
    check("single_code", dut_code(0), 5);
    check("single_onehot", 1 << dut_code(0), 32'h20);
    tick();
    check("single_drop", dut_valid(0), 0);

    // Fixed-priority drain of 6, 1, 3.
    tb_req[6] = 1'b1;
    tb_req[1] = 1'b1;
    tb_req[3] = 1'b1;
    tick();
    tb_req = '0;
    check("drain_g0", dut_code(0), 1);
    tick();
    check("drain_g1", dut_code(0), 3);
    tick();
    check("drain_g2", dut_code(0), 6);
    tick();
    check("drain_valid", dut_valid(0), 0);
    check("drain_pend", dut_pend(0), 0);

    // Backpressure: 2 is held while 0 arrives.
    tb_ready  = 1'b0;
    tb_req[2] = 1'b1;
    tick();
    tb_req = '0;
    check("stall_c0", dut_code(0), 2);
    tb_req[0] = 1'b1;
    tick();
    tb_req = '0;
    check("stall_c1", dut_code(0), 2);
    tick();
    check("stall_c2", dut_code(0), 2);
    tick();
    check("stall_c3", dut_code(0), 2);
    check("stall_pend", dut_pend(0), 8'h05);
    tb_ready = 1'b1;
    tick();
    check("stall_next", dut_code(0), 0);
    tick();
    check("stall_done", dut_valid(0), 0);

    // Set beats clear on a held request.
    tb_req[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_valid", dut_valid(0), 1);
      check("hold_code", dut_code(0), 4);
      check("hold_pend4", (dut_pend(0) >> 4) & 1, 1);
      check("hold_rr_code", dut_code(1), 4);
    end
    tb_req = '0;
    tick();
    tick();

    // Round-robin wrap from a fresh pointer.
    async_reset();
    tb_req = 8'hFF;
    tick();
    tb_req = '0;
    for (int k = 0; k < 8; k++) begin
      check("rr_seq", dut_code(1), k);
      tick();
    end
    check("rr_idle", dut_valid(1), 0);
    tb_req[0] = 1'b1;
    tb_req[7] = 1'b1;
    tick();
    tb_req = '0;
    check("rr_wrap_first", dut_code(1), 0);
    tick();
    check("rr_wrap_second", dut_code(1), 7);
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tb_req   = 8'($urandom & $urandom);
      tb_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end
      tick();
    end
    tb_req   = '0;
    tb_ready = 1'b1;
    repeat (10) tick();
    check("final_fx_pend", dut_pend(0), 0);
    check("final_rr_pend", dut_pend(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
